// File: rtl/sync_event_pkg.sv
// Shared constants and helpers for the multi-channel synchronised event bank.
// Edge-mode codes and the filter counter width calculation live here.
package sync_event_pkg;

    localparam int EDGE_RISE = 32'sd0;
    localparam int EDGE_FALL = 32'sd1;
    localparam int EDGE_BOTH = 32'sd2;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // A zero-length filter still needs one counter bit to keep the port widths legal.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = clog2(filter_len + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: synchroniser chain, glitch filter and edge detector.
// Only sync_r[0] sees the asynchronous input; everything else is fed from registers.
module sync_filter_chan
    import sync_event_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 0,
    parameter int   EDGE_MODE  = 0,
    parameter logic RST_LEVEL  = 1'b0
) (
    input  logic clk_dst,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic pulse
);

    localparam int CW = cnt_width(FILTER_LEN);

    logic [STAGES-1:0] sync_r;
    logic [CW-1:0]     cnt_r;
    logic              filt_r;
    logic              filt_d_r;
    logic              sync_s;
    logic              rise_s;
    logic              fall_s;
    logic              pulse_s;

    // Synchroniser shift chain, newest sample in bit 0.
    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RST_LEVEL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], sig_in};
        end
    end

    assign sync_s = sync_r[STAGES-1];

    // Glitch filter: a new level is accepted only after FILTER_LEN+1 stable cycles.
    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            filt_r   <= RST_LEVEL;
            filt_d_r <= RST_LEVEL;
        end else begin
            filt_d_r <= filt_r;
            if (sync_s == filt_r) begin
                cnt_r <= '0;
            end else if (cnt_r < CW'(FILTER_LEN)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                filt_r <= sync_s;
                cnt_r  <= '0;
            end
        end
    end

    assign rise_s = filt_r & ~filt_d_r;
    assign fall_s = ~filt_r & filt_d_r;

    // Edge selection from the filtered level and its one-cycle-old copy.
    always_comb begin
        pulse_s = 1'b0;
        case (EDGE_MODE)
            EDGE_RISE: pulse_s = rise_s;
            EDGE_FALL: pulse_s = fall_s;
            EDGE_BOTH: pulse_s = rise_s | fall_s;
            default:   pulse_s = rise_s;
        endcase
    end

    assign level = filt_r;
    assign pulse = pulse_s;

endmodule

// File: rtl/sync_event_bank.sv
// Multi-channel event synchroniser with sticky pending/overflow flags and an interrupt.
// Per-channel conditioning is in sync_filter_chan; this level owns the status bank.
module sync_event_bank
    import sync_event_pkg::*;
#(
    parameter int                  CHANNELS   = 4,
    parameter int                  STAGES     = 2,
    parameter int                  FILTER_LEN = 0,
    parameter int                  EDGE_MODE  = 0,
    parameter logic [CHANNELS-1:0] RST_LEVEL  = {CHANNELS{1'b0}}
) (
    input  logic                clk_dst,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] sig_in,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overflow,
    output logic                irq
);

    logic [CHANNELS-1:0] pulse_s;
    logic [CHANNELS-1:0] pending_r;
    logic [CHANNELS-1:0] overflow_r;
    logic [CHANNELS-1:0] pending_nx_s;
    logic [CHANNELS-1:0] overflow_nx_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sync_filter_chan #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .EDGE_MODE  (EDGE_MODE),
            .RST_LEVEL  (RST_LEVEL[i])
        ) u_chan (
            .clk_dst (clk_dst),
            .rst_n   (rst_n),
            .sig_in  (sig_in[i]),
            .level   (level_out[i]),
            .pulse   (pulse_s[i])
        );
    end

    // Sticky flag update: a new event always sets pending, even against a clear.
    always_comb begin
        pending_nx_s  = pending_r;
        overflow_nx_s = overflow_r;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pulse_s[i]) begin
                pending_nx_s[i] = 1'b1;
                if (clr[i]) begin
                    overflow_nx_s[i] = 1'b0;
                end else if (pending_r[i]) begin
                    overflow_nx_s[i] = 1'b1;
                end else begin
                    overflow_nx_s[i] = overflow_r[i];
                end
            end else if (clr[i]) begin
                pending_nx_s[i]  = 1'b0;
                overflow_nx_s[i] = 1'b0;
            end else begin
                pending_nx_s[i]  = pending_r[i];
                overflow_nx_s[i] = overflow_r[i];
            end
        end
    end

    // Status flag registers.
    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= '0;
            overflow_r <= '0;
        end else begin
            pending_r  <= pending_nx_s;
            overflow_r <= overflow_nx_s;
        end
    end

    assign pulse_out = pulse_s;
    assign pending   = pending_r;
    assign overflow  = overflow_r;
    assign irq       = |pending_r;

endmodule

// File: tb/tb_sync_event_bank.sv
// Self-checking bench for sync_event_bank: vector table, directed corner cases,
// and randomized stimulus against a window-based reference model.
module tb_sync_event_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instance A: defaults. B: filter 3, both edges. C: falling edge. D: filter 5.
    logic [3:0] sig_a = 4'h0, clr_a = 4'h0, lvl_a, pls_a, pnd_a, ovf_a;
    logic [3:0] sig_b = 4'h0, clr_b = 4'h0, lvl_b, pls_b, pnd_b, ovf_b;
    logic [3:0] sig_c = 4'h0, clr_c = 4'h0, lvl_c, pls_c, pnd_c, ovf_c;
    logic [3:0] sig_d = 4'h0, clr_d = 4'h0, lvl_d, pls_d, pnd_d, ovf_d;
    logic irq_a, irq_b, irq_c, irq_d;

    sync_event_bank u_a (
        .clk_dst(clk), .rst_n(rst_n), .sig_in(sig_a), .clr(clr_a),
        .level_out(lvl_a), .pulse_out(pls_a), .pending(pnd_a), .overflow(ovf_a), .irq(irq_a));
    sync_event_bank #(.FILTER_LEN(3), .EDGE_MODE(2)) u_b (
        .clk_dst(clk), .rst_n(rst_n), .sig_in(sig_b), .clr(clr_b),
        .level_out(lvl_b), .pulse_out(pls_b), .pending(pnd_b), .overflow(ovf_b), .irq(irq_b));
    sync_event_bank #(.EDGE_MODE(1)) u_c (
        .clk_dst(clk), .rst_n(rst_n), .sig_in(sig_c), .clr(clr_c),
        .level_out(lvl_c), .pulse_out(pls_c), .pending(pnd_c), .overflow(ovf_c), .irq(irq_c));
    sync_event_bank #(.FILTER_LEN(5)) u_d (
        .clk_dst(clk), .rst_n(rst_n), .sig_in(sig_d), .clr(clr_d),
        .level_out(lvl_d), .pulse_out(pls_d), .pending(pnd_d), .overflow(ovf_d), .irq(irq_d));

    typedef struct packed {
        logic [3:0] sig;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] pls;
        logic [3:0] pnd;
        logic [3:0] ovf;
        logic       irq;
    } vec_t;

    vec_t vec [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model for instance B (STAGES=2, FILTER_LEN=3, both edges).
    localparam int M_ST = 2;
    localparam int M_FL = 3;
    logic [3:0] hist [$];
    logic [3:0] m_filt, m_pulse, m_pend, m_ovf;

    // Synchronised value seen by the filter at edge e is the input sampled STAGES edges earlier.
    function automatic logic [3:0] sync_at(input int e);
        int idx;
        idx = e - M_ST;
        if (idx >= 1) return hist[idx-1];
        else return 4'h0;
    endfunction

    task automatic model_edge(input logic [3:0] clr_v);
        int t;
        logic [3:0] old_filt;
        logic [3:0] s;
        logic hold;
        t = hist.size();
        for (int ch = 0; ch < 4; ch++) begin
            if (m_pulse[ch]) begin
                if (clr_v[ch]) m_ovf[ch] = 1'b0;
                else if (m_pend[ch]) m_ovf[ch] = 1'b1;
                m_pend[ch] = 1'b1;
            end else if (clr_v[ch]) begin
                m_pend[ch] = 1'b0;
                m_ovf[ch]  = 1'b0;
            end
        end
        old_filt = m_filt;
        for (int ch = 0; ch < 4; ch++) begin
            hold = 1'b1;
            for (int e = t - M_FL; e <= t; e++) begin
                s = sync_at(e);
                if (s[ch] == old_filt[ch]) hold = 1'b0;
            end
            if (hold) m_filt[ch] = ~old_filt[ch];
        end
        m_pulse = m_filt ^ old_filt;
    endtask

    initial begin
        int first;
        int cnt;
        logic [3:0] s_next;
        logic [3:0] c_next;

        vec[0]  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[1]  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[2]  = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0};
        vec[3]  = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 1'b1};
        vec[4]  = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 1'b1};
        vec[5]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1'b1};
        vec[6]  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1'b1};
        vec[7]  = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 1'b1};
        vec[8]  = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 1'b1};
        vec[9]  = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h4, 1'b1};
        vec[10] = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[11] = '{4'hC, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[12] = '{4'hC, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[13] = '{4'hC, 4'h0, 4'hC, 4'h8, 4'h0, 4'h0, 1'b0};
        vec[14] = '{4'h4, 4'h0, 4'hC, 4'h0, 4'h8, 4'h0, 1'b1};
        vec[15] = '{4'h4, 4'h0, 4'hC, 4'h0, 4'h8, 4'h0, 1'b1};
        vec[16] = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 1'b1};
        vec[17] = '{4'hC, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 1'b1};
        vec[18] = '{4'hC, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 1'b1};
        vec[19] = '{4'hC, 4'h0, 4'hC, 4'h8, 4'h8, 4'h0, 1'b1};
        vec[20] = '{4'hC, 4'h8, 4'hC, 4'h0, 4'h8, 4'h0, 1'b1};
        vec[21] = '{4'hC, 4'h8, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[22] = '{4'hF, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[23] = '{4'hF, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[24] = '{4'hF, 4'h0, 4'hF, 4'h3, 4'h0, 4'h0, 1'b0};
        vec[25] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h3, 4'h0, 1'b1};

        // Reset values with all inputs high, then the first event after release.
        sig_a = 4'hF;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_level", lvl_a, 4'h0);
        chk("rst_pulse", pls_a, 4'h0);
        chk("rst_pending", pnd_a, 4'h0);
        chk("rst_overflow", ovf_a, 4'h0);
        chk("rst_irq", irq_a, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rel_e1_pulse", pls_a, 4'h0);
        tick();
        chk("rel_e2_level", lvl_a, 4'h0);
        chk("rel_e2_pulse", pls_a, 4'h0);
        tick();
        chk("rel_e3_level", lvl_a, 4'hF);
        chk("rel_e3_pulse", pls_a, 4'hF);
        tick();
        chk("rel_e4_pulse", pls_a, 4'h0);
        chk("rel_e4_pending", pnd_a, 4'hF);

        // Vector table: overflow, clear, set-wins-over-clear, simultaneous events.
        sig_a = 4'h0;
        do_reset();
        for (int r = 0; r < 26; r++) begin
            sig_a = vec[r].sig;
            clr_a = vec[r].clr;
            tick();
            chk($sformatf("vec%0d_level", r), lvl_a, vec[r].lvl);
            chk($sformatf("vec%0d_pulse", r), pls_a, vec[r].pls);
            chk($sformatf("vec%0d_pending", r), pnd_a, vec[r].pnd);
            chk($sformatf("vec%0d_overflow", r), ovf_a, vec[r].ovf);
            chk($sformatf("vec%0d_irq", r), irq_a, vec[r].irq);
        end
        clr_a = 4'h0;

        // Filter: short glitch dropped, long pulse accepted with fixed latency.
        sig_b = 4'h0;
        do_reset();
        tick();
        sig_b = 4'h1;
        tick();
        tick();
        sig_b = 4'h0;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (pls_b[0] || lvl_b[0]) cnt++;
        end
        chk("glitch_dropped", cnt, 0);
        sig_b = 4'h1;
        first = -1;
        cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (pls_b[0]) begin
                if (first < 0) first = n;
                cnt++;
            end
            if (n == 10) sig_b = 4'h0;
        end
        chk("filt_latency", first, 6);
        chk("filt_both_count", cnt, 2);
        // Both-edge mode: three toggles on ch1 give three events.
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            if (n == 0 || n == 6 || n == 12) sig_b[1] = ~sig_b[1];
            tick();
            if (pls_b[1]) cnt++;
        end
        chk("both_pulses", cnt, 3);
        chk("both_pending1", pnd_b[1], 1'b1);

        // Falling-edge mode: rise is ignored, fall makes one event.
        sig_c = 4'h0;
        do_reset();
        sig_c = 4'h2;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (pls_c[1]) cnt++;
        end
        chk("fall_rise_ignored", cnt, 0);
        chk("fall_level_high", lvl_c[1], 1'b1);
        sig_c = 4'h0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (pls_c[1]) cnt++;
        end
        chk("fall_one_pulse", cnt, 1);
        chk("fall_pending", pnd_c, 4'h2);

        // Reset while the filter counter is part way up, input low across release.
        sig_d = 4'h0;
        do_reset();
        sig_d = 4'h1;
        for (int n = 0; n < 5; n++) tick();
        rst_n = 1'b0;
        sig_d = 4'h0;
        tick();
        chk("midrst_level", lvl_d, 4'h0);
        chk("midrst_pulse", pls_d, 4'h0);
        chk("midrst_irq", irq_d, 1'b0);
        rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (pls_d[0] || lvl_d[0]) cnt++;
        end
        chk("midrst_no_event", cnt, 0);
        sig_d = 4'h1;
        first = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (pls_d[0] && first < 0) first = n;
        end
        chk("midrst_full_latency", first, 8);

        // Randomized run on instance B against the reference model.
        sig_b = 4'h0;
        clr_b = 4'h0;
        do_reset();
        hist.delete();
        m_filt = 4'h0;
        m_pulse = 4'h0;
        m_pend = 4'h0;
        m_ovf = 4'h0;
        for (int n = 0; n < 600; n++) begin
            s_next = sig_b;
            c_next = 4'h0;
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(4, 0) == 0) s_next[ch] = ~s_next[ch];
                if ($urandom_range(7, 0) == 0) c_next[ch] = 1'b1;
            end
            sig_b = s_next;
            clr_b = c_next;
            tick();
            hist.push_back(s_next);
            model_edge(c_next);
            chk($sformatf("rnd%0d_level", n), lvl_b, m_filt);
            chk($sformatf("rnd%0d_pulse", n), pls_b, m_pulse);
            chk($sformatf("rnd%0d_pending", n), pnd_b, m_pend);
            chk($sformatf("rnd%0d_overflow", n), ovf_b, m_ovf);
            chk($sformatf("rnd%0d_irq", n), irq_b, |m_pend);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
